// File: rtl/chunked_adder_pkg.sv
// Shared types and helpers for the chunked multi-cycle adder.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the chunk index counter; never narrower than one bit so a
    // single-chunk configuration still has a real (constant-zero) register.
    function automatic int idx_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/chunked_adder_chunk_full_adder.sv
// N-bit ripple of full adders. Also exposes the carry into the top bit so the
// parent can form a signed overflow flag from the last chunk.
module chunk_full_adder
    import chunked_adder_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic carry;

    // Ripple the carry bit by bit, recording the carry that enters the MSB.
    always_comb begin
        carry    = ci;
        c_msb_in = 1'b0;
        s        = '0;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) begin
                c_msb_in = carry;
            end
            s[i]  = x[i] ^ y[i] ^ carry;
            carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands CHUNK bits per clock with the
// inter-chunk carry held in a register. Valid/ready handshakes on both sides.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | in_ready=1, waiting for operands; last result still visible
//  ADD   | one chunk added per cycle, idx selects the chunk
//  DONE  | out_valid=1, result held until out_ready
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             signed_md,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $fatal(1, "chunked_adder: WIDTH must be >= 1 and a multiple of CHUNK");
    end

    localparam int            NCHUNK   = WIDTH / CHUNK;
    localparam int            IW       = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             smd_q, smd_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             co_chunk, c_msb_in;

    // Select the chunk currently being added from the captured operands.
    always_comb begin
        a_chunk = CHUNK'(a_q >> (idx_q * CHUNK));
        b_chunk = CHUNK'(b_q >> (idx_q * CHUNK));
    end

    chunk_full_adder #(.N(CHUNK)) u_fa (
        .x        (a_chunk),
        .y        (b_chunk),
        .ci       (carry_q),
        .s        (s_chunk),
        .co       (co_chunk),
        .c_msb_in (c_msb_in)
    );

    // Next-state logic: capture in IDLE, one chunk per ADD cycle, hold in DONE.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        smd_d       = smd_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    smd_d   = signed_md;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[idx_q*CHUNK +: CHUNK] = s_chunk;
                carry_d = co_chunk;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    cout_d      = co_chunk;
                    ovf_d       = smd_q ? (c_msb_in ^ co_chunk) : co_chunk;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State, datapath and result registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            smd_q       <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            smd_q       <= smd_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
